// File: rtl/drawbridge_plant.sv
// Closed-loop plant model for the DrawBridge controller: bridge travel, car crossing,
// sensor generation and a sticky safety-violation flag.
module drawbridge_plant #(
    parameter int unsigned TRAVEL = 8,
    parameter int unsigned CROSS  = 4,
    parameter int unsigned CW     = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          MT,
    input  logic          MDIR,
    input  logic          TFL,
    input  logic          CAR_REQ,
    input  logic          FAULT_H,
    output logic          H,
    output logic          L,
    output logic          CAIN,
    output logic          CAO,
    output logic [CW-1:0] Pos,
    output logic          OnBridge,
    output logic          COLL
);

    localparam int unsigned     CntW    = (CROSS > 1) ? $clog2(CROSS) : 1;
    localparam logic [CW-1:0]   PosMax  = CW'(TRAVEL);
    localparam logic [CntW-1:0] CntLoad = CntW'(CROSS - 1);

    typedef enum logic [1:0] {StIdle, StEnter, StCross, StExit} car_state_e;

    car_state_e      state_q, state_d;
    logic [CW-1:0]   pos_q, pos_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cain_q, cain_d;
    logic            cao_q, cao_d;
    logic            coll_q, coll_d;
    logic            moving;
    logic            on_bridge;

    always_comb begin
        // Motion saturates at both ends; "moving" means Pos actually changes this edge.
        moving = MT & (MDIR ? (pos_q < PosMax) : (pos_q != '0));
        pos_d  = pos_q;
        if (moving) begin
            pos_d = MDIR ? pos_q + CW'(1) : pos_q - CW'(1);
        end

        on_bridge = (state_q != StIdle);
        state_d   = state_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (TFL && CAR_REQ) begin
                    state_d = StEnter;
                end
            end
            StEnter: begin
                state_d = StCross;
                cnt_d   = CntLoad;
            end
            StCross: begin
                if (cnt_q == '0) begin
                    state_d = StExit;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StExit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        cain_d = (state_d == StEnter);
        cao_d  = (state_d == StExit);
        coll_d = coll_q | ((state_q == StEnter) & (pos_q != '0)) | (on_bridge & moving);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            pos_q   <= '0;
            cnt_q   <= '0;
            cain_q  <= 1'b0;
            cao_q   <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            cain_q  <= cain_d;
            cao_q   <= cao_d;
            coll_q  <= coll_d;
        end
    end

    assign Pos      = pos_q;
    assign H        = (pos_q == PosMax) | FAULT_H;
    assign L        = (pos_q == '0);
    assign CAIN     = cain_q;
    assign CAO      = cao_q;
    assign OnBridge = on_bridge;
    assign COLL     = coll_q;

endmodule

// File: tb/tb_drawbridge_plant.sv
// Bench for drawbridge_plant: directed scenarios followed by random stimulus, all
// compared against a cycle-count model of bridge position and car progress.
module tb_drawbridge_plant;

    localparam int TRAVEL = 8;
    localparam int CROSS  = 4;
    localparam int CW     = 4;

    logic          Clk;
    logic          Reset, MT, MDIR, TFL, CAR_REQ, FAULT_H;
    logic          H, L, CAIN, CAO, OnBridge, COLL;
    logic [CW-1:0] Pos;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: position as an integer, car as cycles since entry (-1 = no car).
    // Entry cycle is 0, crossing cycles 1..CROSS, exit cycle CROSS+1.
    int m_pos  = 0;
    int m_car  = -1;
    bit m_coll = 0;

    drawbridge_plant #(
        .TRAVEL (TRAVEL),
        .CROSS  (CROSS),
        .CW     (CW)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .MT       (MT),
        .MDIR     (MDIR),
        .TFL      (TFL),
        .CAR_REQ  (CAR_REQ),
        .FAULT_H  (FAULT_H),
        .H        (H),
        .L        (L),
        .CAIN     (CAIN),
        .CAO      (CAO),
        .Pos      (Pos),
        .OnBridge (OnBridge),
        .COLL     (COLL)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge using the inputs the DUT sampled.
    task automatic model_step();
        bit moving;
        int next_pos;
        if (Reset) begin
            m_pos  = 0;
            m_car  = -1;
            m_coll = 0;
            return;
        end
        next_pos = m_pos;
        if (MT && MDIR && m_pos < TRAVEL) next_pos = m_pos + 1;
        if (MT && !MDIR && m_pos > 0) next_pos = m_pos - 1;
        moving = (next_pos != m_pos);
        if (m_car == 0 && m_pos != 0) m_coll = 1;
        if (m_car >= 0 && moving) m_coll = 1;
        m_pos = next_pos;
        if (m_car < 0) begin
            if (TFL && CAR_REQ) m_car = 0;
        end else if (m_car == CROSS + 1) begin
            m_car = -1;
        end else begin
            m_car = m_car + 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".Pos"}, 32'(Pos), 32'(m_pos));
        check({tag, ".H"}, 32'(H), 32'((m_pos == TRAVEL) || FAULT_H));
        check({tag, ".L"}, 32'(L), 32'(m_pos == 0));
        check({tag, ".CAIN"}, 32'(CAIN), 32'(m_car == 0));
        check({tag, ".CAO"}, 32'(CAO), 32'(m_car == CROSS + 1));
        check({tag, ".OnBridge"}, 32'(OnBridge), 32'(m_car >= 0));
        check({tag, ".COLL"}, 32'(COLL), 32'(m_coll));
    endtask

    task automatic tick(input string tag);
        @(posedge Clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        Reset = 1'b1; MT = 1'b0; MDIR = 1'b0; TFL = 1'b0; CAR_REQ = 1'b0; FAULT_H = 1'b0;

        // 1. Reset state
        tick("reset");
        check("reset.L_lit", 32'(L), 32'd1);
        check("reset.COLL_lit", 32'(COLL), 32'd0);
        Reset = 1'b0;

        // 2. Raise past the top; saturates at TRAVEL
        MT = 1'b1; MDIR = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick("raise");
            if (i == 1) check("raise.L_after1", 32'(L), 32'd0);
            if (i == 8) check("raise.H_after8", 32'(H), 32'd1);
        end
        check("raise.Pos_sat", 32'(Pos), 32'd8);

        // 3. Lower back to flat
        MDIR = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick("lower");
            if (i == 1) check("lower.H_after1", 32'(H), 32'd0);
        end
        check("lower.Pos0", 32'(Pos), 32'd0);
        check("lower.L", 32'(L), 32'd1);
        MT = 1'b0;

        // 4. Continuous car traffic on a flat bridge
        TFL = 1'b1; CAR_REQ = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick("cars");
            if (i == 1 || i == 8) check("cars.CAIN_lit", 32'(CAIN), 32'd1);
            if (i == 6) check("cars.CAO_lit", 32'(CAO), 32'd1);
        end
        check("cars.COLL_lit", 32'(COLL), 32'd0);
        TFL = 1'b0; CAR_REQ = 1'b0;
        for (int i = 0; i < 8; i++) tick("drain");

        // 5. Fault injection on H is combinational and leaves L/Pos alone
        FAULT_H = 1'b1;
        #1;
        check("fault.H", 32'(H), 32'd1);
        check("fault.L", 32'(L), 32'd1);
        tick("fault");
        check("fault.Pos", 32'(Pos), 32'd0);
        FAULT_H = 1'b0;

        // 6. Bridge moves with a car on it, then reset mid-raise
        TFL = 1'b1; CAR_REQ = 1'b1;
        tick("coll_enter");
        TFL = 1'b0; CAR_REQ = 1'b0;
        tick("coll_cross");
        MT = 1'b1; MDIR = 1'b1;
        tick("coll_move");
        check("coll.set", 32'(COLL), 32'd1);
        for (int i = 0; i < 3; i++) tick("coll_raise");
        check("coll.Pos4", 32'(Pos), 32'd4);
        check("coll.sticky", 32'(COLL), 32'd1);
        Reset = 1'b1;
        tick("coll_reset");
        check("coll.reset_Pos", 32'(Pos), 32'd0);
        check("coll.reset_COLL", 32'(COLL), 32'd0);
        check("coll.reset_idle", 32'(OnBridge), 32'd0);
        Reset = 1'b0; MT = 1'b0;

        // Random closed-loop stimulus
        for (int i = 0; i < 600; i++) begin
            Reset   = ($urandom_range(0, 59) == 0);
            MT      = ($urandom_range(0, 2) != 0);
            MDIR    = $urandom_range(0, 1) != 0;
            TFL     = $urandom_range(0, 1) != 0;
            CAR_REQ = $urandom_range(0, 1) != 0;
            FAULT_H = ($urandom_range(0, 7) == 0);
            #1;
            check("rand.H_comb", 32'(H), 32'((m_pos == TRAVEL) || FAULT_H));
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
